cont_regressivo: RTL and testbench
==================================

Name: cont_regressivo

Overview:
- Parametrised synchronous down-counter; next generation of the fixed 5-to-0 counter used by the irrigation timing logic.
- Adds configurable width and start value, runtime load, count enable, one-shot/auto-reload mode, terminal-count flags and a one-cycle Done pulse.
- Sits between the irrigation FSM and the valve/timer outputs. The FSM loads a duration and waits for Done.

Parameters:
- WIDTH, 3, counter width in bits (1..16).
- START, 5, value loaded on reset into both Q and the reload register. Must be < 2^WIDTH.

Ports:
- Clk  in  1  single clock; all state changes on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- En  in  1  count enable. Advances the counter one step per cycle when high.
- Load  in  1  synchronous load strobe.
- LoadVal  in  WIDTH  value taken by Load.
- Mode  in  1  0 = one-shot (stop at 0); 1 = auto-reload.
- Q  out  WIDTH  current count, registered.
- Zero  out  1  high whenever Q == 0; combinational decode of Q.
- Done  out  1  registered one-cycle pulse, high in the cycle Q first shows 0 after a 1->0 step.
- Busy  out  1  high while the FSM is in state RUN.

Behaviour:
- Reset (Rst=1 at an edge; highest priority, overrides Load and En):
  - Q=START, reload register R=START, Done=0.
  - State = RUN if START != 0, else STOP.
- FSM states: RUN (counting), STOP (held at 0). The Busy output equals (state == RUN).
- Priority each edge: Rst > Load > En.
- Load=1:
  - Q<=LoadVal, R<=LoadVal, Done<=0.
  - State<=RUN if LoadVal != 0, else STOP.
  - Load is accepted in any state and mid-count; En is ignored that cycle.
- RUN, En=1, Q>1: Q<=Q-1, Done<=0.
- RUN, En=1, Q==1: Q<=0, Done<=1.
  - Mode=0: state<=STOP.
  - Mode=1: state stays RUN.
  - Mode is sampled only at this edge.
- RUN, En=1, Q==0 (auto-reload only): Q<=R, Done<=0. Zero is therefore high for exactly one enabled cycle per period, and the period is R+1 enabled cycles.
- RUN, En=1, Q==0, R==0: state<=STOP, Q stays 0, no Done pulse. This case prevents a stuck-pulse condition.
- En=0: Q, R and state hold. Done<=0, so Done never stretches over stalls.
- STOP: Q held at 0 and En is ignored. Exit only via Load with a non-zero value, or via Rst.
- Counter never wraps below 0. No underflow path exists.
- Arithmetic is unsigned, modulo-free: the decrement is only applied when Q>=1.
- Latency:
  - Load to Q visible: 1 cycle.
  - N=LoadVal enabled cycles from load to Done=1.
- Rst mid-count: Done cleared the same edge; no residual pulse.

Test Plan:
- Reset, WIDTH=3, START=5, Mode=0, En=1 constant -> Q=5,4,3,2,1,0. Done=1 only in the cycle Q=0, then Busy=0. Q stays 0 for 10 more cycles and Done stays 0.
- Mode=1, Load LoadVal=3, En=1 -> Q=3,2,1,0,3,2,1,0. Done pulses each time Q reaches 0 (period 4). Busy stays 1.
- Mid-count control: at Q=2, drop En for 3 cycles -> Q holds at 2 and Done stays 0. Then Load=1 with LoadVal=6 and En=1 -> next Q=6 (load wins over En), followed by 5,4...
- Zero-value loads: Load LoadVal=0 -> Q=0, Busy=0, Done never asserts. Then Mode=1 with R=0 reached via reload -> transitions to STOP with no pulse.
- Rst asserted in the same cycle as Load=1 (LoadVal=7) while Q=1 and En=1 -> next Q=5, Done=0, Busy=1 (reset priority).
- WIDTH=8, START=200, Mode=0 -> exactly 200 enabled cycles to Done. Q never wraps to 255.

Source files
------------

// File: rtl/cont_regressivo_if.sv
// cont_regressivo_if: control and status bundle between the irrigation FSM and the down-counter
interface cont_regressivo_if #(parameter int WIDTH = 3);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] loadval;
  logic             mode;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             done;
  logic             busy;
  modport master (output en, load, loadval, mode, input q, zero, done, busy);
  modport slave (input en, load, loadval, mode, output q, zero, done, busy);
endinterface

// File: rtl/cont_regressivo.sv
// cont_regressivo: loadable down-counter with one-shot/auto-reload modes and a one-cycle done pulse
module cont_regressivo #(
  parameter int          WIDTH = 3,
  parameter int unsigned START = 5
) (
  input logic              clk,
  input logic              rst,
  cont_regressivo_if.slave bus
);
  typedef enum logic {STOP, RUN} state_t;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  state_t           state, state_n;
  logic [WIDTH-1:0] q, q_n, r, r_n;
  logic             done, done_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= WIDTH'(START);
      r     <= WIDTH'(START);
      done  <= 1'b0;
      state <= (START != 0) ? RUN : STOP;
    end else begin
      q     <= q_n;
      r     <= r_n;
      done  <= done_n;
      state <= state_n;
    end
  end
  // Decrement only from q>=1; q==0 in RUN means auto-reload, or stop if the reload value is 0
  always_comb begin
    state_n = state;
    q_n     = q;
    r_n     = r;
    done_n  = 1'b0;
    if (bus.load) begin
      q_n     = bus.loadval;
      r_n     = bus.loadval;
      state_n = (bus.loadval != '0) ? RUN : STOP;
    end else if (state == RUN && bus.en) begin
      if (q > ONE) begin
        q_n = q - ONE;
      end else if (q == ONE) begin
        q_n     = '0;
        done_n  = 1'b1;
        state_n = bus.mode ? RUN : STOP;
      end else begin
        q_n     = r;
        state_n = (r == '0) ? STOP : RUN;
      end
    end
  end
  assign bus.q    = q;
  assign bus.zero = (q == '0);
  assign bus.done = done;
  assign bus.busy = (state == RUN);
endmodule

// File: tb/tb_cont_regressivo.sv
// tb_cont_regressivo: directed checks of a 3-bit/START=5 counter and an 8-bit/START=200 counter
module tb_cont_regressivo;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   fails = 0;
  cont_regressivo_if #(.WIDTH(3)) a ();
  cont_regressivo_if #(.WIDTH(8)) b ();
  cont_regressivo #(.WIDTH(3), .START(5)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  cont_regressivo #(.WIDTH(8), .START(200)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_a(input string tag, input int eq, input bit ed, input bit eb);
    chk({tag, " q"}, a.q, eq);
    chk({tag, " done"}, a.done, ed);
    chk({tag, " busy"}, a.busy, eb);
    chk({tag, " zero"}, a.zero, eq == 0);
  endtask
  initial begin
    int seq[9];
    int done_at, done_cnt;
    bit wrapped;
    rst = 1'b1;
    a.en = 1'b1; a.load = 1'b0; a.loadval = '0; a.mode = 1'b0;
    b.en = 1'b0; b.load = 1'b0; b.loadval = '0; b.mode = 1'b0;
    step();
    chk_a("reset", 5, 0, 1);
    chk("reset b q", b.q, 200);
    rst = 1'b0;
    for (int v = 4; v >= 1; v--) begin
      step();
      chk_a("oneshot", v, 0, 1);
    end
    step();
    chk_a("oneshot end", 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_a("stop hold", 0, 0, 0);
    end
    a.mode = 1'b1; a.load = 1'b1; a.loadval = 3'd3;
    step();
    a.load = 1'b0;
    chk_a("reload load", 3, 0, 1);
    seq = '{2, 1, 0, 3, 2, 1, 0, 3, 2};
    for (int i = 0; i < 9; i++) begin
      step();
      chk_a("autoreload", seq[i], seq[i] == 0, 1);
    end
    a.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a("stall", 2, 0, 1);
    end
    a.en = 1'b1; a.load = 1'b1; a.loadval = 3'd6;
    step();
    a.load = 1'b0;
    chk_a("load over en", 6, 0, 1);
    step();
    chk_a("after load", 5, 0, 1);
    step();
    chk_a("after load", 4, 0, 1);
    a.load = 1'b1; a.loadval = 3'd0;
    step();
    a.load = 1'b0;
    chk_a("load zero", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a("zero stop", 0, 0, 0);
    end
    a.load = 1'b1; a.loadval = 3'd1;
    step();
    a.load = 1'b0;
    chk_a("load one", 1, 0, 1);
    step();
    chk_a("one to zero", 0, 1, 1);
    step();
    chk_a("reload one", 1, 0, 1);
    rst = 1'b1; a.load = 1'b1; a.loadval = 3'd7;
    step();
    rst = 1'b0; a.load = 1'b0;
    chk_a("rst over load", 5, 0, 1);
    a.en = 1'b0;
    b.en = 1'b1;
    done_at = 0; done_cnt = 0; wrapped = 1'b0;
    for (int i = 1; i <= 210; i++) begin
      step();
      if (b.q > 8'd200) wrapped = 1'b1;
      if (b.done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
    end
    chk("w8 cycles to done", done_at, 200);
    chk("w8 done pulses", done_cnt, 1);
    chk("w8 no wrap", wrapped, 0);
    chk("w8 final q", b.q, 0);
    chk("w8 final busy", b.busy, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
